// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared op encodings, FSM state type and default latencies
//                for the multi-cycle multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Decoder MultDivControl encodings; bit 1 distinguishes divide from multiply
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Default busy durations
    localparam int c_DEF_MULT_CYCLES = 5;
    localparam int c_DEF_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_compute.sv
`default_nettype none
// ============================================================================
//  Module      : md_compute
//  Description : Combinational multiply/divide datapath. Produces the packed
//                {hi,lo} result, including divide-by-zero and the signed
//                overflow case 0x80000000 / -1.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_compute
    import md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_n;
    logic [31:0] w_div_d;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_signed_div;
    logic        w_q_neg;
    logic        w_r_neg;

    // Products, magnitude-based division and sign fix-up for the selected op
    always_comb begin
        // Sign-extending to 64 bits makes the truncated unsigned product equal
        // the two's-complement signed product.
        w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        w_umul = {32'b0, a} * {32'b0, b};

        w_signed_div = (op == MD_DIV);
        // Negating 0x80000000 yields 0x80000000, which is the correct magnitude
        // when read as unsigned, so the overflow case falls out naturally.
        w_abs_a = (w_signed_div && a[31]) ? (32'd0 - a) : a;
        w_abs_b = (w_signed_div && b[31]) ? (32'd0 - b) : b;
        w_div_n = w_abs_a;
        // Guard the divider against a zero divisor; that case is overridden below.
        w_div_d = (b == 32'd0) ? 32'd1 : w_abs_b;
        w_uq    = w_div_n / w_div_d;
        w_ur    = w_div_n % w_div_d;
        w_q_neg = w_signed_div && (a[31] ^ b[31]);
        w_r_neg = w_signed_div && a[31];

        result = 64'd0;
        case (op)
            MD_MULT:  result = w_smul;
            MD_MULTU: result = w_umul;
            default: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result[63:32] = w_r_neg ? (32'd0 - w_ur) : w_ur;
                    result[31:0]  = w_q_neg ? (32'd0 - w_uq) : w_uq;
                end
            end
        endcase
    end

endmodule : md_compute
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage multi-cycle multiply/divide unit with architectural
//                HI/LO registers, fixed latency busy flag, mthi/mtlo writes
//                and exception-flush gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = c_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = c_DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    md_state_t          r_state;
    md_state_t          w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic [63:0]        r_pending;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [63:0]        w_result;
    logic               w_launch;
    logic               w_finish;
    logic               w_hi_wr;
    logic               w_lo_wr;

    // Result is computed from the operands present in the launch cycle and
    // parked in the pending register until the latency has elapsed.
    md_compute u_compute (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (w_result)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: launch on an unflushed start, retire when the counter expires
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start && !flush) w_next_state = BUSY;
            BUSY:    if (r_count == c_CNT_W'(1)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output/control decode; busy comes straight from the state register
    always_comb begin
        w_launch = (r_state == IDLE) && start && !flush;
        w_finish = (r_state == BUSY) && (r_count == c_CNT_W'(1));
        // start has priority over mthi/mtlo in the same cycle
        w_hi_wr  = (r_state == IDLE) && !flush && !start && hi_we;
        w_lo_wr  = (r_state == IDLE) && !flush && !start && lo_we;
        busy     = (r_state == BUSY);
    end

    // Latency counter and pending result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_pending <= 64'd0;
        end else if (w_launch) begin
            r_count   <= op[1] ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
            r_pending <= w_result;
        end else if (r_state == BUSY) begin
            r_count   <= r_count - c_CNT_W'(1);
        end
    end

    // Architectural HI/LO: retired result or mthi/mtlo data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_finish) begin
            r_hi <= r_pending[63:32];
            r_lo <= r_pending[31:0];
        end else begin
            if (w_hi_wr) r_hi <= wdata;
            if (w_lo_wr) r_lo <= wdata;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : mult_div_unit
`default_nettype wire
